// File: rtl/mem_boot_arbiter.sv
// mem_boot_arbiter: owns the single memory port and sequences the boot.
// While in HOLD an external loader fills memory with the core held in reset.
// On start, the port stays idle for a few cycles and then the core takes over.
// A halt returns the arbiter to load mode.
// Optional feature macro MEM_WP_EN: in RUN, core writes at or above PROG_BASE
// are dropped and latched in the sticky wp_fault flag.
module mem_boot_arbiter #(
  parameter int                    ADDR_WIDTH     = 16,
  parameter int                    DATA_WIDTH     = 8,
  parameter logic [ADDR_WIDTH-1:0] PROG_BASE      = 'h0600,
  parameter int                    RELEASE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  halt,
  input  logic                  ext_req,
  input  logic                  ext_we,
  input  logic [ADDR_WIDTH-1:0] ext_addr,
  input  logic [DATA_WIDTH-1:0] ext_din,
  output logic                  ext_ack,
  output logic                  ext_rvalid,
  output logic [DATA_WIDTH-1:0] ext_rdata,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [DATA_WIDTH-1:0] core_din,
  input  logic                  core_we,
  output logic                  core_reset_n,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic                  running,
  output logic [15:0]           load_count,
  output logic                  wp_fault
);

  // A release length of 0 behaves like 1: the port is always idle for at
  // least one cycle before the core gets it.
  localparam int RELEASE_N = (RELEASE_CYCLES < 1) ? 1 : RELEASE_CYCLES;
  localparam int CNT_W     = (RELEASE_N > 1) ? $clog2(RELEASE_N) : 1;
  localparam logic [CNT_W-1:0] REL_LAST = CNT_W'(RELEASE_N - 1);

  typedef enum logic [1:0] {
    S_HOLD    = 2'd0,
    S_RELEASE = 2'd1,
    S_RUN     = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] rel_cnt;
  logic             ext_rd_acc;
  logic             ext_wr_acc;
  logic             wp_hit;

  // Next-state logic: halt has priority over start in every state.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path
    // through the block can leave it unassigned and infer a latch.
    state_next = state;
    unique case (state)
      S_HOLD: begin
        // A loader access in the same cycle as start wins; start is dropped.
        if (!halt && start && !ext_req) state_next = S_RELEASE;
      end
      S_RELEASE: begin
        if (halt)                    state_next = S_HOLD;
        else if (rel_cnt == REL_LAST) state_next = S_RUN;
      end
      S_RUN: begin
        if (halt) state_next = S_HOLD;
      end
      default: state_next = S_HOLD;
    endcase
  end

  // Memory port mux: loader in HOLD, nothing in RELEASE, core in RUN.
  always_comb begin
    mem_addr   = '0;
    mem_din    = '0;
    mem_we     = 1'b0;
    ext_ack    = 1'b0;
    ext_rd_acc = 1'b0;
    ext_wr_acc = 1'b0;
    wp_hit     = 1'b0;
    unique case (state)
      S_HOLD: begin
        ext_ack    = ext_req;
        ext_rd_acc = ext_req & ~ext_we;
        ext_wr_acc = ext_req & ext_we;
        mem_addr   = ext_addr;
        mem_din    = ext_din;
        mem_we     = ext_req & ext_we;
      end
      S_RUN: begin
        mem_addr = core_addr;
        mem_din  = core_din;
`ifdef MEM_WP_EN
        wp_hit   = core_we && (core_addr >= PROG_BASE);
`endif
        mem_we   = core_we & ~wp_hit;
      end
      default: ;
    endcase
  end

  // State register and release-delay counter.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!reset_n) begin
      state   <= S_HOLD;
      rel_cnt <= '0;
    end else begin
      state   <= state_next;
      rel_cnt <= (state == S_RELEASE) ? rel_cnt + 1'b1 : '0;
    end
  end

  // Core-side status: registered so they change exactly on RUN entry/exit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      core_reset_n <= 1'b0;
      running      <= 1'b0;
    end else begin
      core_reset_n <= (state_next == S_RUN);
      running      <= (state_next == S_RUN);
    end
  end

  // Loader read return: valid follows the accepted read by one cycle, data is
  // captured from memory at the end of that valid cycle and held.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ext_rvalid <= 1'b0;
      ext_rdata  <= '0;
    end else begin
      ext_rvalid <= ext_rd_acc;
      if (ext_rvalid) ext_rdata <= mem_dout;
    end
  end

  // Saturating count of accepted loader writes; retained across RUN.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      load_count <= '0;
    end else if (ext_wr_acc && (load_count != 16'hFFFF)) begin
      load_count <= load_count + 16'd1;
    end
  end

`ifdef MEM_WP_EN
  // Sticky write-protect flag, cleared when the arbiter re-enters HOLD.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp_fault <= 1'b0;
    end else if (state_next == S_HOLD && state != S_HOLD) begin
      wp_fault <= 1'b0;
    end else if (wp_hit) begin
      wp_fault <= 1'b1;
    end
  end
`else
  assign wp_fault = 1'b0;
  // Keeps PROG_BASE referenced when protection is compiled out.
  logic unused_wp;
  assign unused_wp = (core_addr >= PROG_BASE) | wp_hit;
`endif

endmodule

// File: tb/tb_mem_boot_arbiter.sv
// tb_mem_boot_arbiter: directed bench for mem_boot_arbiter with a behavioural
// synchronous memory. Loader read results go through a scoreboard queue that
// a negedge monitor drains whenever ext_rvalid is seen.
module tb_mem_boot_arbiter;

  localparam int AW = 16;
  localparam int DW = 8;
`ifdef MEM_WP_EN
  localparam bit WP = 1'b1;
`else
  localparam bit WP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start, halt;
  logic          ext_req, ext_we;
  logic [AW-1:0] ext_addr;
  logic [DW-1:0] ext_din;
  logic          ext_ack, ext_rvalid;
  logic [DW-1:0] ext_rdata;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_din;
  logic          core_we;
  logic          core_reset_n;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic          mem_we;
  logic [DW-1:0] mem_dout;
  logic          running;
  logic [15:0]   load_count;
  logic          wp_fault;

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] exp_q[$];

  mem_boot_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PROG_BASE(16'h0600), .RELEASE_CYCLES(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .halt(halt),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_din(ext_din),
    .ext_ack(ext_ack), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .core_addr(core_addr), .core_din(core_din), .core_we(core_we),
    .core_reset_n(core_reset_n), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_we(mem_we), .mem_dout(mem_dout), .running(running),
    .load_count(load_count), .wp_fault(wp_fault)
  );

  always #5 clk = ~clk;

  // Behavioural memory: read data one cycle after the address.
  logic [DW-1:0] mem [0:65535];
  initial for (int i = 0; i < 65536; i++) mem[i] = '0;
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_din;
    mem_dout <= mem[mem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: ext_rdata is captured at the end of the rvalid cycle, so it is
  // compared one negedge after the rvalid it belongs to.
  logic          pend = 1'b0;
  logic [DW-1:0] pend_exp;
  always @(negedge clk) begin
    if (!reset_n) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        check("rdata", ext_rdata, pend_exp);
        pend = 1'b0;
      end
      if (ext_rvalid) begin
        if (exp_q.size() == 0) begin
          check("rvalid_unexpected", 1, 0);
        end else begin
          pend_exp = exp_q.pop_front();
          pend     = 1'b1;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    start = 0; halt = 0; ext_req = 0; ext_we = 0; core_we = 0;
  endtask

  task automatic ld_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    idle();
    ext_req = 1; ext_we = 1; ext_addr = a; ext_din = d;
    #1;
    check("ld_write_ack", ext_ack, 1);
    check("ld_write_we", mem_we, 1);
    step();
    idle();
  endtask

  task automatic ld_read(input logic [AW-1:0] a, input logic [DW-1:0] d);
    idle();
    ext_req = 1; ext_we = 0; ext_addr = a;
    exp_q.push_back(d);
    #1;
    check("ld_read_ack", ext_ack, 1);
    check("ld_read_we", mem_we, 0);
    step();
    idle();
  endtask

  // Issue start from HOLD and advance to the first RUN cycle.
  task automatic boot();
    idle();
    start = 1;
    step();
    idle();
    step();
    step();
  endtask

  task automatic drain();
    repeat (3) step();
    check("queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    reset_n = 0; idle();
    ext_addr = '0; ext_din = '0; core_addr = '0; core_din = '0;
    #12;
    check("rst_core_reset_n", core_reset_n, 0);
    check("rst_running", running, 0);
    check("rst_rvalid", ext_rvalid, 0);
    check("rst_rdata", ext_rdata, 0);
    check("rst_load_count", load_count, 0);
    check("rst_wp_fault", wp_fault, 0);
    reset_n = 1;
    step();

    // 1: load and read back, core held in reset.
    ld_write(16'h0010, 8'hA5);
    ld_write(16'h0600, 8'h3C);
    ld_read(16'h0010, 8'hA5);
    ld_read(16'h0600, 8'h3C);
    check("t1_core_reset_n", core_reset_n, 0);
    drain();
    check("t1_load_count", load_count, 2);
    check("t1_core_reset_n_end", core_reset_n, 0);

    // 2: start pulse, two idle cycles, then RUN; loader ignored in RUN.
    start = 1;
    #1;
    step();
    idle();
    core_we = 1; core_addr = 16'h0030; core_din = 8'hEE;
    ext_req = 1; ext_we = 1; ext_addr = 16'h0010; ext_din = 8'hFF;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("t2_rel_we", mem_we, 0);
      check("t2_rel_addr", mem_addr, 0);
      check("t2_rel_ack", ext_ack, 0);
      check("t2_rel_core_reset_n", core_reset_n, 0);
      check("t2_rel_running", running, 0);
      step();
    end
    core_we = 0;
    #1;
    check("t2_run_core_reset_n", core_reset_n, 1);
    check("t2_run_running", running, 1);
    check("t2_run_ack", ext_ack, 0);
    check("t2_run_we", mem_we, 0);
    step();
    check("t2_run_load_count", load_count, 2);
    halt = 1; ext_req = 0;
    step();
    idle();
    check("t2_halt_core_reset_n", core_reset_n, 0);
    check("t2_halt_running", running, 0);
    ld_read(16'h0010, 8'hA5);
    ld_read(16'h0030, 8'h00);
    drain();

    // 3: start collides with a loader access, then halt+start in RELEASE.
    start = 1; ext_req = 1; ext_we = 0; ext_addr = 16'h0600;
    exp_q.push_back(8'h3C);
    #1;
    check("t3_collide_ack", ext_ack, 1);
    step();
    ld_read(16'h0010, 8'hA5);
    start = 1;
    step();
    idle();
    start = 1; halt = 1; ext_req = 1; ext_we = 0; ext_addr = 16'h0010;
    #1;
    check("t3_release_ack", ext_ack, 0);
    step();
    idle();
    ld_read(16'h0600, 8'h3C);
    step();
    step();
    check("t3_stays_hold", core_reset_n, 0);
    drain();

    // 4: core writes, halt-cycle write completes, async reset mid-RUN.
    boot();
    check("t4_running", running, 1);
    core_we = 1; core_addr = 16'h0020; core_din = 8'h77;
    #1;
    check("t4_core_we", mem_we, 1);
    check("t4_core_addr", mem_addr, 16'h0020);
    step();
    halt = 1; core_addr = 16'h0021; core_din = 8'h78;
    step();
    idle();
    check("t4_halt_core_reset_n", core_reset_n, 0);
    check("t4_halt_running", running, 0);
    ld_read(16'h0020, 8'h77);
    ld_read(16'h0021, 8'h78);
    drain();
    check("t4_load_count_kept", load_count, 2);
    boot();
    check("t4_pre_reset_running", running, 1);
    #2;
    reset_n = 0;
    #1;
    check("t4_async_core_reset_n", core_reset_n, 0);
    check("t4_async_running", running, 0);
    check("t4_async_load_count", load_count, 0);
    #3;
    reset_n = 1;
    step();
    ext_req = 1; ext_we = 1; ext_addr = 16'h0040; ext_din = 8'h55;
    #1;
    check("t4_after_reset_hold", ext_ack, 1);
    step();
    idle();

    // 5: core write into the program region.
    boot();
    core_we = 1; core_addr = 16'h0600; core_din = 8'h11;
    #1;
    check("t5_wp_mem_we", mem_we, WP ? 0 : 1);
    step();
    core_we = 0;
    check("t5_wp_fault", wp_fault, WP ? 1 : 0);
    halt = 1;
    step();
    idle();
    check("t5_wp_fault_cleared", wp_fault, 0);
    ld_read(16'h0600, WP ? 8'h3C : 8'h11);
    drain();

    // 6: load_count saturation (one write already counted after reset).
    for (int i = 0; i < 65536; i++) begin
      if (i == 65534) check("t6_count_65535", load_count, 16'hFFFF);
      ext_req = 1; ext_we = 1; ext_addr = 16'h0100; ext_din = i[7:0];
      step();
    end
    idle();
    #1;
    check("t6_saturated", load_count, 16'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_boot_arbiter.md
Name: mem_boot_arbiter

Overview:
- Owns the single memory port. Sequences the boot: an external loader fills memory while the core is held in reset, then control hands over cleanly to the core datapath (fetcher/decoder/address bus).
- Replaces the ad-hoc manual-memory muxing and reset juggling in the instruction-flow bench with synthesizable control.
- Sits between the mem instance, the core's memory-side signals and the chip-level reset.

Parameters:
- ADDR_WIDTH, 16, memory address width.
- DATA_WIDTH, 8, memory data width.
- PROG_BASE, 16'h0600, first address of the program region. Used by the write-protect feature.
- RELEASE_CYCLES, 2, cycles the port stays idle between the end of loading and core reset release. A value of 0 is treated as 1.

Ports:
- clk  in  1  block clock (the memory clock domain).
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  request to leave load mode and boot the core.
- halt  in  1  request to stop the core and return to load mode.
- ext_req  in  1  loader access request.
- ext_we  in  1  loader write enable. 0 means read.
- ext_addr  in  ADDR_WIDTH  loader address.
- ext_din  in  DATA_WIDTH  loader write data.
- ext_ack  out  1  loader access accepted this cycle.
- ext_rvalid  out  1  loader read data valid.
- ext_rdata  out  DATA_WIDTH  loader read data.
- core_addr  in  ADDR_WIDTH  core memory address.
- core_din  in  DATA_WIDTH  core write data.
- core_we  in  1  core write enable.
- core_reset_n  out  1  reset to the core datapath, active-low.
- mem_addr  out  ADDR_WIDTH  address to mem.
- mem_din  out  DATA_WIDTH  write data to mem.
- mem_we  out  1  write enable to mem.
- mem_dout  in  DATA_WIDTH  read data from mem. Valid the cycle after the address is presented.
- running  out  1  high in RUN.
- load_count  out  16  number of accepted loader writes. Saturates at 16'hFFFF.
- wp_fault  out  1  sticky write-protect violation flag.

Behaviour:
- Decided: one clock, clk. reset_n is asynchronous and active-low.
- Reset values:
  - State HOLD.
  - core_reset_n=0, running=0.
  - ext_rvalid=0, ext_rdata=0.
  - load_count=0, wp_fault=0.
  - All registered state is cleared immediately on reset assertion, mid-operation included.
- States: HOLD (loader owns port, core in reset), RELEASE (port idle, core in reset), RUN (core owns port).
- HOLD:
  - ext_ack = ext_req (combinational).
  - mem_addr=ext_addr. mem_din=ext_din. mem_we=ext_req&ext_we.
  - Accepted write: load_count increments next edge, saturating.
  - Accepted read in cycle N: ext_rvalid=1 in cycle N+1, and ext_rdata is registered from mem_dout at the end of N+1 (held until the next read).
  - Back-to-back accesses are allowed every cycle.
- HOLD -> RELEASE: start=1 and ext_req=0.
  - If start and ext_req arrive in the same cycle, the access is accepted and start is dropped. The loader must reassert start.
- RELEASE:
  - mem_we=0, mem_addr=0, ext_ack=0.
  - Internal counter runs max(RELEASE_CYCLES,1) cycles, then the state moves to RUN.
  - halt in RELEASE aborts back to HOLD.
- RUN:
  - core_reset_n=1 and running=1, both registered and asserted the first cycle of RUN.
  - mem_addr=core_addr. mem_din=core_din. mem_we=core_we.
  - ext_req is ignored: ext_ack=0, no memory effect, no counter change.
- RUN -> HOLD on halt:
  - core_reset_n=0 and running=0 from the next cycle.
  - The core's write in the halt cycle still completes.
  - load_count is retained.
- halt and start in the same cycle: halt wins everywhere. In HOLD, halt is a no-op.
- ext_rvalid is only ever driven by reads accepted in HOLD. A read accepted in the last HOLD cycle still returns ext_rvalid in the following cycle.
- load_count does not wrap: writes past 65535 leave it at 16'hFFFF.

Optional Feature:
- MEM_WP_EN defined:
  - In RUN, a core write with core_addr >= PROG_BASE is suppressed (mem_we=0).
  - wp_fault sets the next cycle and stays set until reset or entry into HOLD.
  - Loader writes in HOLD are never protected.
- MEM_WP_EN undefined: core writes pass unconditionally and wp_fault is tied to 0.

Test Plan:
1. Reset, then loader writes 0xA5 @0x0010 and 0x3C @0x0600, then reads both. Required:
   - ext_ack each cycle.
   - ext_rvalid one cycle after each read, returning 0xA5 then 0x3C.
   - load_count=2.
   - core_reset_n=0 throughout.
2. start pulse with RELEASE_CYCLES=2. Required:
   - Exactly 2 idle cycles with mem_we=0.
   - core_reset_n and running rise on cycle 3.
   - Loader ext_req in RUN gets ext_ack=0 and memory is unchanged (0x0010 still 0xA5 after halt and readback).
3. start and ext_req together in HOLD. Required:
   - The access completes and the state remains HOLD.
   - start on the next cycle alone enters RELEASE.
   - halt+start together in RELEASE returns to HOLD.
4. In RUN, core writes 0x77 @0x0020, then halt. Required:
   - core_reset_n=0 the next cycle.
   - Loader reads 0x77 @0x0020.
   - Asynchronous reset_n pulse mid-RUN forces HOLD and core_reset_n=0 immediately.
5. With MEM_WP_EN, core writes 0x11 @0x0600 in RUN. Required:
   - mem_we stays 0 and wp_fault=1.
   - After halt, wp_fault=0 and 0x0600 still reads 0x3C.
   - Without the macro, the same write lands and wp_fault stays 0.
6. 65537 loader writes. Required: load_count saturates at 16'hFFFF.
